// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch queue.
//   XLEN_DEF    - default address/instruction width
//   INSTR_BYTES - bytes per instruction; fetch PC advances by this amount
//   fq_entry_t  - layout of one queue entry {pc, instr} at the default width;
//                 the queue stores entries packed in this same order.
package fetch_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the fetch queue's control, memory and decode-side
// signals.
//   control : redirect, redirect_pc, stall           (into the queue)
//   memory  : imem_req, imem_addr                    (out of the queue)
//             imem_ready, imem_rvalid, imem_rdata    (into the queue)
//   decode  : instr_valid, instr, instr_pc, pc_plus4 (out of the queue)
// The master modport is the fetch queue; slave is its environment.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) ();

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            stall;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic [XLEN-1:0] pc_plus4;

    modport master (
        input  redirect, redirect_pc, stall,
        input  imem_ready, imem_rvalid, imem_rdata,
        output imem_req, imem_addr,
        output instr_valid, instr, instr_pc, pc_plus4
    );

    modport slave (
        output redirect, redirect_pc, stall,
        output imem_ready, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr,
        input  instr_valid, instr, instr_pc, pc_plus4
    );

endinterface

// File: rtl/fq_fifo.sv
// fq_fifo: synchronous FIFO with combinational read of the head entry.
//   CLK, reset : clock, synchronous active-high reset (pointers/count only)
//   flush      : empties the FIFO at the next edge, overrides push/pop
//   push/wdata : write an entry (ignored when full and not popping)
//   pop        : remove the head entry (ignored when empty)
//   rdata      : head entry (stale contents when empty)
//   count      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module fq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop && (count_q != '0);
    // A full FIFO can still accept a write when its head leaves the same cycle.
    assign do_push = push && ((count_q != FULL_CNT) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is defined by the count alone.
    always_ff @(posedge CLK) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a small decoupling queue.
//   CLK   : clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   bus   : fetch_queue_if.master
//           - issues sequential fetches from fpc while queue + in-flight < DEPTH
//           - tags each in-order response with the PC of its request
//           - presents the head entry combinationally to decode
//           - redirect flushes the queue, reloads fpc and marks all still
//             outstanding responses for discard
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic           CLK,
    input logic           reset,
    fetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] OCC_LIMIT = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic [CW-1:0]   count;      // entries in the instruction queue
    logic [CW-1:0]   inflight;   // accepted requests awaiting a response
    logic [CW:0]     occupancy;
    logic [XLEN-1:0] rsp_pc;
    logic [2*XLEN-1:0] head;
    logic            req, accept, rsp, keep, pop, head_valid;

    // Every PC in flight holds a slot, so the queue can never overflow.
    assign occupancy = {1'b0, count} + {1'b0, inflight};
    assign req       = !reset && !bus.redirect && (occupancy < OCC_LIMIT);
    assign accept    = req && bus.imem_ready;
    // A response with nothing outstanding (e.g. after reset) is ignored.
    assign rsp       = bus.imem_rvalid && (inflight != '0);
    // Responses to requests issued before a redirect are dropped; a response
    // landing in the redirect cycle itself is dropped as well.
    assign keep      = rsp && (discard_q == '0) && !bus.redirect;
    assign head_valid = !reset && (count != '0);
    assign pop       = head_valid && !bus.stall && !bus.redirect;

    // In-flight PCs in request order; popped on every response, stale or not.
    fq_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .CLK   (CLK),
        .reset (reset),
        .flush (1'b0),
        .push  (accept),
        .wdata (fpc_q),
        .pop   (rsp),
        .rdata (rsp_pc),
        .count (inflight)
    );

    // Instruction queue: entries packed as {pc, instr}.
    fq_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .CLK   (CLK),
        .reset (reset),
        .flush (bus.redirect),
        .push  (keep),
        .wdata ({rsp_pc, bus.imem_rdata}),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

    always_comb begin
        fpc_d     = fpc_q;
        discard_d = discard_q;
        if (bus.redirect) begin
            fpc_d     = {bus.redirect_pc[XLEN-1:2], 2'b00};
            // Everything still outstanding after this cycle's response is stale.
            discard_d = inflight - CW'(rsp);
        end else begin
            if (accept) fpc_d = fpc_q + XLEN'(INSTR_BYTES);
            if (rsp && (discard_q != '0)) discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            fpc_q     <= {RESET_PC[XLEN-1:2], 2'b00};
            discard_q <= '0;
        end else begin
            fpc_q     <= fpc_d;
            discard_q <= discard_d;
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = reset ? '0 : fpc_q;
    assign bus.instr_valid = head_valid;
    assign bus.instr_pc    = head_valid ? head[2*XLEN-1:XLEN] : '0;
    assign bus.instr       = head_valid ? head[XLEN-1:0] : '0;
    assign bus.pc_plus4    = head_valid ? head[2*XLEN-1:XLEN] + XLEN'(INSTR_BYTES) : '0;

endmodule
